song_sequencer: RTL and testbench

//  Parametrised song reader. Walks one song of a multi-song note ROM, one entry at a time,
//  and hands {note, duration} to the note player with a new_note pulse. Adds an external
//  ROM port with configurable read latency, early end-of-song on a zero-duration entry,

---
 rtl/song_sequencer.sv | 165 ++++++++++++++++
 tb/tb_song_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Song reader: walks one song of a multi-song note ROM and hands {note, duration}
// to the note player, with configurable ROM latency, loop, pause and song restart.
module song_sequencer #(
    parameter int SONG_BITS   = 2,
    parameter int IDX_BITS    = 5,
    parameter int NOTE_W      = 6,
    parameter int DUR_W       = 6,
    parameter int ROM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_BITS-1:0]          song,
    input  logic                          loop,
    input  logic                          note_done,
    output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_data,
    output logic [NOTE_W-1:0]             note,
    output logic [DUR_W-1:0]              duration,
    output logic                          new_note,
    output logic                          song_done,
    output logic [IDX_BITS-1:0]           note_idx
);

    localparam int                LAT_W    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(ROM_LATENCY - 1);
    localparam logic [IDX_BITS-1:0] IDX_LAST = '1;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
    } entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_END,
        S_STOPPED
    } state_t;

    state_t                state, state_nxt;
    entry_t                rom_entry;
    logic [SONG_BITS-1:0]  song_q, song_q_nxt;
    logic [IDX_BITS-1:0]   idx, idx_nxt;
    logic [LAT_W-1:0]      lat_cnt, lat_nxt;
    logic                  song_chg;
    logic                  restart;
    logic                  idx_inc;
    logic                  lat_inc;
    logic                  latch_entry;

    assign rom_entry = rom_data;
    assign song_chg  = (song != song_q);

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Nothing advances while paused; a song change aborts from any active state.
    always_comb begin
        state_nxt   = state;
        restart     = 1'b0;
        idx_inc     = 1'b0;
        lat_inc     = 1'b0;
        latch_entry = 1'b0;
        if (play) begin
            if (song_chg && state != S_IDLE) begin
                state_nxt = S_FETCH;
                restart   = 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        state_nxt = S_FETCH;
                        restart   = 1'b1;
                    end
                    S_FETCH: begin
                        if (lat_cnt == LAT_LAST) begin
                            if (rom_entry.dur == '0) begin
                                state_nxt = S_END;
                            end else begin
                                state_nxt   = S_ISSUE;
                                latch_entry = 1'b1;
                            end
                        end else begin
                            lat_inc = 1'b1;
                        end
                    end
                    S_ISSUE: state_nxt = S_WAIT;
                    S_WAIT: begin
                        if (note_done) begin
                            if (idx == IDX_LAST) begin
                                state_nxt = S_END;
                            end else begin
                                state_nxt = S_FETCH;
                                idx_inc   = 1'b1;
                            end
                        end
                    end
                    S_END: begin
                        if (loop) begin
                            state_nxt = S_FETCH;
                            restart   = 1'b1;
                        end else begin
                            state_nxt = S_STOPPED;
                        end
                    end
                    S_STOPPED: state_nxt = S_STOPPED;
                    default:   state_nxt = S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        new_note  = 1'b0;
        song_done = 1'b0;
        if (!reset && play && !song_chg) begin
            new_note  = (state == S_ISSUE);
            song_done = (state == S_END);
        end
    end

    always_comb begin
        song_q_nxt = song_q;
        idx_nxt    = idx;
        lat_nxt    = lat_cnt;
        if (restart) begin
            song_q_nxt = song;
            idx_nxt    = '0;
            lat_nxt    = '0;
        end else if (idx_inc) begin
            idx_nxt = idx + IDX_BITS'(1);
            lat_nxt = '0;
        end else if (lat_inc) begin
            lat_nxt = lat_cnt + LAT_W'(1);
        end
    end

    // rom_addr is loaded from the same next values as song_q/idx so it always mirrors them.
    always_ff @(posedge clk) begin
        if (reset) begin
            song_q   <= song;
            idx      <= '0;
            lat_cnt  <= '0;
            rom_addr <= {song, {IDX_BITS{1'b0}}};
            note     <= '0;
            duration <= '0;
            note_idx <= '0;
        end else begin
            song_q   <= song_q_nxt;
            idx      <= idx_nxt;
            lat_cnt  <= lat_nxt;
            rom_addr <= {song_q_nxt, idx_nxt};
            if (latch_entry) begin
                note     <= rom_entry.note;
                duration <= rom_entry.dur;
                note_idx <= idx;
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench: one-cycle ROM instance for the main walk, three-cycle instance for latency.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       play_a, loop_a, note_done_a;
    logic [1:0] song_a;
    logic [6:0] rom_addr_a;
    logic [11:0] rom_data_a;
    logic [5:0] note_a, duration_a;
    logic       new_note_a, song_done_a;
    logic [4:0] note_idx_a;

    logic       play_b, loop_b, note_done_b;
    logic [1:0] song_b;
    logic [6:0] rom_addr_b;
    logic [11:0] rom_data_b, rb1, rb2;
    logic [5:0] note_b, duration_b;
    logic       new_note_b, song_done_b;
    logic [4:0] note_idx_b;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

    always #5 clk = ~clk;

    // Song s entry i: note = i ^ (s<<4), dur = i + s + 1; song 1 entry 3 and song 3 entry 2 end early.
    function automatic logic [5:0] exp_note(input int s, input int i);
        return 6'((i ^ (s << 4)) & 63);
    endfunction

    function automatic logic [5:0] exp_dur(input int s, input int i);
        if ((s == 1 && i == 3) || (s == 3 && i == 2)) return 6'd0;
        return 6'(i + s + 1);
    endfunction

    function automatic logic [11:0] rom_word(input logic [6:0] a);
        return {exp_note(int'(a[6:5]), int'(a[4:0])), exp_dur(int'(a[6:5]), int'(a[4:0]))};
    endfunction

    assign rom_data_a = rom_word(rom_addr_a);

    always @(posedge clk) begin
        rb1 <= rom_word(rom_addr_b);
        rb2 <= rb1;
    end
    assign rom_data_b = rb2;

    song_sequencer #(.ROM_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .play(play_a), .song(song_a), .loop(loop_a),
        .note_done(note_done_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .note(note_a), .duration(duration_a), .new_note(new_note_a),
        .song_done(song_done_a), .note_idx(note_idx_a)
    );

    song_sequencer #(.ROM_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .play(play_b), .song(song_b), .loop(loop_b),
        .note_done(note_done_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .note(note_b), .duration(duration_b), .new_note(new_note_b),
        .song_done(song_done_b), .note_idx(note_idx_b)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_note_a(input int s, input int i);
        int n = 0;
        while (new_note_a !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("new_note_seen", 32'(new_note_a), 1);
        check("note_idx", 32'(note_idx_a), 32'(i));
        check("note", 32'(note_a), 32'(exp_note(s, i)));
        check("duration", 32'(duration_a), 32'(exp_dur(s, i)));
    endtask

    task automatic finish_note_a(input int gap);
        repeat (gap) tick();
        note_done_a = 1'b1;
        tick();
        note_done_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1; play_a = 1'b0; loop_a = 1'b0; note_done_a = 1'b0; song_a = 2'd0;
        play_b = 1'b0; loop_b = 1'b0; note_done_b = 1'b0; song_b = 2'd0;
        tick(); tick();
        check("rst_note", 32'(note_a), 0);
        check("rst_duration", 32'(duration_a), 0);
        check("rst_note_idx", 32'(note_idx_a), 0);
        check("rst_new_note", 32'(new_note_a), 0);
        check("rst_song_done", 32'(song_done_a), 0);
        check("rst_rom_addr", 32'(rom_addr_a), 0);
        reset = 1'b0;
        repeat (4) tick();

        // Three-cycle ROM: first note four edges after play is sampled, then next note after note_done.
        play_b = 1'b1;
        tick();
        check("b_rom_addr", 32'(rom_addr_b), 0);
        check("b_nn_e0", 32'(new_note_b), 0);
        tick(); check("b_nn_e1", 32'(new_note_b), 0);
        tick(); check("b_nn_e2", 32'(new_note_b), 0);
        tick();
        check("b_nn_e3", 32'(new_note_b), 1);
        check("b_note0", 32'(note_b), 32'(exp_note(0, 0)));
        check("b_dur0", 32'(duration_b), 32'(exp_dur(0, 0)));
        tick();
        note_done_b = 1'b1;
        tick();
        note_done_b = 1'b0;
        tick(); check("b_nn_f1", 32'(new_note_b), 0);
        tick(); check("b_nn_f2", 32'(new_note_b), 0);
        tick();
        check("b_nn_f3", 32'(new_note_b), 1);
        check("b_note1", 32'(note_b), 32'(exp_note(0, 1)));
        check("b_dur1", 32'(duration_b), 32'(exp_dur(0, 1)));
        check("b_idx1", 32'(note_idx_b), 1);

        // Full 32-entry walk of song 0, then a single song_done and STOPPED.
        play_a = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wait_note_a(0, i);
            finish_note_a(5);
        end
        check("t1_song_done", 32'(song_done_a), 1);
        check("t1_new_note_at_end", 32'(new_note_a), 0);
        pulses = 0;
        repeat (10) begin
            tick();
            pulses += int'(new_note_a) + int'(song_done_a);
        end
        check("t1_stopped_quiet", 32'(pulses), 0);
        check("t1_stopped_addr", 32'(rom_addr_a), 31);

        // Song 1 ends early on the zero-duration entry 3.
        song_a = 2'd1;
        tick();
        check("t2_restart_addr", 32'(rom_addr_a), 32);
        for (int i = 0; i < 3; i++) begin
            wait_note_a(1, i);
            finish_note_a(2);
        end
        check("t2_fetch3_nn", 32'(new_note_a), 0);
        tick();
        check("t2_song_done", 32'(song_done_a), 1);
        check("t2_no_4th_note", 32'(new_note_a), 0);
        check("t2_hold_idx", 32'(note_idx_a), 2);
        pulses = 0;
        repeat (5) begin
            tick();
            pulses += int'(new_note_a);
        end
        check("t2_stopped_quiet", 32'(pulses), 0);

        // Loop mode on the two-entry song 3.
        loop_a = 1'b1;
        song_a = 2'd3;
        wait_note_a(3, 0);
        finish_note_a(1);
        wait_note_a(3, 1);
        finish_note_a(1);
        tick();
        check("t4_song_done", 32'(song_done_a), 1);
        tick();
        check("t4_refetch_nn", 32'(new_note_a), 0);
        tick();
        wait_note_a(3, 0);

        // Pause in WAIT while note_done toggles.
        tick();
        play_a = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            note_done_a = k[0];
            tick();
            pulses += int'(new_note_a) + int'(song_done_a);
        end
        note_done_a = 1'b0;
        check("t5_pause_quiet", 32'(pulses), 0);
        check("t5_pause_idx", 32'(note_idx_a), 0);
        check("t5_pause_addr", 32'(rom_addr_a), 96);
        play_a = 1'b1;
        tick(); tick();
        check("t5_resume_wait", 32'(new_note_a), 0);
        finish_note_a(0);
        check("t5_fetch_nn", 32'(new_note_a), 0);
        tick();
        check("t5_resume_nn", 32'(new_note_a), 1);
        check("t5_resume_idx", 32'(note_idx_a), 1);
        check("t5_resume_note", 32'(note_a), 32'(exp_note(3, 1)));

        // Song change mid-WAIT at idx 7, then reset mid-FETCH.
        loop_a = 1'b0;
        song_a = 2'd0;
        tick();
        for (int i = 0; i < 7; i++) begin
            wait_note_a(0, i);
            finish_note_a(1);
        end
        wait_note_a(0, 7);
        tick();
        song_a = 2'd2;
        check("t6_no_done_now", 32'(song_done_a), 0);
        tick();
        check("t6_addr", 32'(rom_addr_a), 64);
        check("t6_no_done", 32'(song_done_a), 0);
        check("t6_fetch_nn", 32'(new_note_a), 0);
        tick();
        check("t6_nn", 32'(new_note_a), 1);
        check("t6_note", 32'(note_a), 32'(exp_note(2, 0)));
        check("t6_dur", 32'(duration_a), 32'(exp_dur(2, 0)));
        check("t6_idx", 32'(note_idx_a), 0);
        finish_note_a(1);
        reset = 1'b1;
        tick();
        check("t6_rst_note", 32'(note_a), 0);
        check("t6_rst_dur", 32'(duration_a), 0);
        check("t6_rst_idx", 32'(note_idx_a), 0);
        check("t6_rst_nn", 32'(new_note_a), 0);
        check("t6_rst_done", 32'(song_done_a), 0);
        check("t6_rst_addr", 32'(rom_addr_a), 64);
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
